// File: rtl/echo_delay_ctrl.sv
// Echo delay FIFO sequencer: keeps delay-FIFO occupancy equal to the selected echo delay.
// Latency: sample_pulse 3 sysclk after a data_valid rise; wrreq/rdreq combinational in the pulse cycle; echo_en one cycle after.
// Backpressure: never writes while fifo_full, never reads while fifo_empty; full/empty faults raise sticky ovf and re-flush.
module echo_delay_ctrl #(
    parameter int FIFO_DEPTH = 1024,
    parameter int AW         = 10,
    parameter int DELAY_STEP = 64
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          data_valid,
    input  logic [3:0]    delay_sel,
    input  logic          fifo_full,
    input  logic          fifo_empty,
    output logic          sample_pulse,
    output logic          fifo_wrreq,
    output logic          fifo_rdreq,
    output logic          echo_en,
    output logic [AW:0]   level,
    output logic          ovf
);

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [11:0] STEP_W  = 12'(DELAY_STEP);
    localparam logic [11:0] MAX_W   = 12'(FIFO_DEPTH - 1);
    localparam logic [AW:0] LVL_ONE = {{AW{1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, edge_q, pulse_q;
    logic [3:0]    delay_q, delay_d;
    logic [AW:0]   level_q, level_d;
    logic          echo_q;
    logic          ovf_q, ovf_d;
    logic          wr, rd;
    logic [11:0]   target_raw;
    logic [11:0]   target_w;

    // Delay target in samples, computed at 12 bits so code 15 with large steps cannot wrap before the clamp.
    assign target_raw = ({8'd0, delay_q} + 12'd1) * STEP_W;
    assign target_w   = (target_raw > MAX_W) ? MAX_W : target_raw;

    // Two-flop synchroniser plus edge-detect register; the pulse itself is registered so each rise yields one clean cycle.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= data_valid;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            pulse_q <= sync2_q & ~edge_q;
        end
    end

    // Next-state, FIFO request and level bookkeeping; all requests are qualified by the FIFO flags.
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        wr      = 1'b0;
        rd      = 1'b0;

        if (pulse_q) begin
            delay_d = delay_sel;
        end

        case (state_q)
            ST_FLUSH: begin
                // Drain whatever is left (stale after reset or from the old delay); strobes are ignored here.
                rd = ~fifo_empty;
                if (fifo_empty) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (fifo_full) begin
                    ovf_d   = 1'b1;
                    state_d = ST_FLUSH;
                end else if (pulse_q) begin
                    wr = 1'b1;
                    // Once the target is reached the oldest word leaves as the new one enters.
                    if (12'(level_q) == target_w) begin
                        rd      = ~fifo_empty;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (pulse_q) begin
                    if (delay_sel != delay_q) begin
                        state_d = ST_FLUSH;
                    end else if (fifo_full) begin
                        ovf_d   = 1'b1;
                        state_d = ST_FLUSH;
                    end else if (fifo_empty) begin
                        ovf_d   = 1'b1;
                        wr      = 1'b1;
                        state_d = ST_FLUSH;
                    end else begin
                        wr = 1'b1;
                        rd = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase

        // Level restarts from zero whenever filling begins; it never goes below zero while draining stale words.
        if ((state_q == ST_FLUSH) && (state_d == ST_FILL)) begin
            level_d = '0;
        end else if (wr && !rd) begin
            level_d = level_q + LVL_ONE;
        end else if (rd && !wr && (level_q != '0)) begin
            level_d = level_q - LVL_ONE;
        end
    end

    // State, delay code, level, echo gate and sticky error registers.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FLUSH;
            delay_q <= 4'd0;
            level_q <= '0;
            echo_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            delay_q <= delay_d;
            level_q <= level_d;
            echo_q  <= (state_d == ST_RUN);
            ovf_q   <= ovf_d;
        end
    end

    assign sample_pulse = pulse_q;
    assign fifo_wrreq   = wr & ~reset;
    assign fifo_rdreq   = rd & ~reset;
    assign echo_en      = echo_q;
    assign level        = level_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Bench for echo_delay_ctrl with a counting FIFO model and a cycle reference model of the sequencing rules.
// Inputs change 1 ns after posedge; outputs are sampled 1 ns after negedge.
// Scenario tasks run in sequence and finish with one summary line.
module tb_echo_delay_ctrl;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int STEP  = 4;
    localparam int M_FLUSH = 0;
    localparam int M_FILL  = 1;
    localparam int M_RUN   = 2;

    logic          sysclk = 1'b0;
    logic          reset;
    logic          data_valid;
    logic [3:0]    delay_sel;
    logic          fifo_full, fifo_empty;
    logic          sample_pulse, fifo_wrreq, fifo_rdreq, echo_en, ovf;
    logic [AW:0]   level;

    int  n_vec = 0;
    int  n_err = 0;
    int  fifo_cnt = 0;
    int  fifo_preset = 0;
    logic force_full = 1'b0;
    int  rd_total = 0;
    int  viol = 0;

    // reference model state
    int  m_mode = M_FLUSH;
    int  m_lvl = 0;
    int  m_dq = 0;
    bit  m_ovf = 0, m_echo = 0, m_pulse = 0;
    bit [3:0] dvh = 4'd0;
    bit  e_wr = 0, e_rd = 0, l_full = 0, l_empty = 1, obs_wr = 0, obs_rd = 0;
    int  l_dsel = 0;

    echo_delay_ctrl #(.FIFO_DEPTH(DEPTH), .AW(AW), .DELAY_STEP(STEP)) dut (
        .sysclk(sysclk), .reset(reset), .data_valid(data_valid), .delay_sel(delay_sel),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .sample_pulse(sample_pulse),
        .fifo_wrreq(fifo_wrreq), .fifo_rdreq(fifo_rdreq), .echo_en(echo_en),
        .level(level), .ovf(ovf)
    );

    always #5 sysclk = ~sysclk;

    assign fifo_full  = force_full || (fifo_cnt >= DEPTH);
    assign fifo_empty = (fifo_cnt == 0);

    function automatic int tgt(input int dq);
        int t;
        t = (dq + 1) * STEP;
        return (t > DEPTH - 1) ? DEPTH - 1 : t;
    endfunction

    // Occupancy counter standing in for the delay FIFO; it keeps its contents across reset.
    always @(posedge sysclk) begin
        if (reset) fifo_cnt <= fifo_preset;
        else fifo_cnt <= fifo_cnt + ((obs_wr && !l_full) ? 1 : 0) - ((obs_rd && !l_empty) ? 1 : 0);
    end

    // Expected requests for this cycle, from the rules of each mode.
    always @(negedge sysclk) begin
        l_full  = fifo_full;
        l_empty = fifo_empty;
        l_dsel  = int'(delay_sel);
        obs_wr  = fifo_wrreq;
        obs_rd  = fifo_rdreq;
        e_wr = 0;
        e_rd = 0;
        if (!reset) begin
            if (m_mode == M_FLUSH) e_rd = !l_empty;
            else if (m_mode == M_FILL && !l_full && m_pulse) begin
                e_wr = 1;
                e_rd = (m_lvl == tgt(m_dq)) && !l_empty;
            end else if (m_mode == M_RUN && m_pulse && l_dsel == m_dq && !l_full) begin
                e_wr = 1;
                e_rd = !l_empty;
            end
        end
        if ((fifo_rdreq && fifo_empty) || (fifo_wrreq && fifo_full)) viol++;
        if (fifo_rdreq) rd_total++;
    end

    // Mode transitions, level count and pulse prediction from the data_valid history.
    always @(posedge sysclk or posedge reset) begin
        int nm;
        if (reset) begin
            m_mode = M_FLUSH; m_lvl = 0; m_dq = 0; m_ovf = 0; m_echo = 0; m_pulse = 0; dvh = 4'd0;
        end else begin
            nm = m_mode;
            if (m_mode == M_FLUSH) begin
                if (l_empty) nm = M_FILL;
            end else if (m_mode == M_FILL) begin
                if (l_full) begin nm = M_FLUSH; m_ovf = 1; end
                else if (m_pulse && m_lvl == tgt(m_dq)) nm = M_RUN;
            end else if (m_pulse) begin
                if (l_dsel != m_dq) nm = M_FLUSH;
                else if (l_full || l_empty) begin nm = M_FLUSH; m_ovf = 1; end
            end
            if (nm == M_FILL && m_mode == M_FLUSH) m_lvl = 0;
            else begin
                m_lvl = m_lvl + int'(e_wr) - int'(e_rd);
                if (m_lvl < 0) m_lvl = 0;
            end
            if (m_pulse) m_dq = l_dsel;
            m_echo = (nm == M_RUN);
            m_mode = nm;
            dvh = {dvh[2:0], data_valid};
            // a rise that entered the synchroniser three edges ago
            m_pulse = dvh[2] && !dvh[3];
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge sysclk); #1; end
    endtask

    // One data_valid strobe; reports what happened in the pulse cycle and the cycle after it.
    task automatic pulse_once(input int hi, input int lo, output bit w, output bit r,
                              output bit e_at, output bit e_after, output int npulse);
        bit prev;
        w = 0; r = 0; e_at = 0; e_after = 0; npulse = 0; prev = 0;
        data_valid = 1'b1;
        for (int c = 0; c < hi + lo; c++) begin
            if (c == hi) data_valid = 1'b0;
            @(negedge sysclk); #1;
            if (prev) e_after = echo_en;
            prev = 0;
            if (sample_pulse === 1'b1) begin
                npulse++;
                w = fifo_wrreq; r = fifo_rdreq; e_at = echo_en; prev = 1;
            end
            @(posedge sysclk); #1;
        end
    endtask

    task automatic test_reset;
        logic [9:0] pat, want;
        logic [AW+3:0] o;
        reset = 1'b1; data_valid = 1'b0; delay_sel = 4'd0; fifo_preset = 5;
        repeat (3) @(posedge sysclk);
        #1;
        @(negedge sysclk); #1;
        o = {sample_pulse, fifo_wrreq, fifo_rdreq, echo_en, level};
        n_vec++;
        if (o !== '0 || ovf !== 1'b0) begin
            n_err++; $display("FAIL reset_values: got %b ovf=%b, want all zero", o, ovf);
        end
        @(posedge sysclk); #1;
        reset = 1'b0;
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk); #1;
            pat = {pat[8:0], fifo_rdreq};
            @(posedge sysclk); #1;
        end
        want = 10'b1111100000;
        n_vec++;
        if (pat !== want) begin n_err++; $display("FAIL reset_flush_rd: got %b want %b", pat, want); end
        n_vec++;
        if ({level, echo_en, ovf} !== '0) begin
            n_err++; $display("FAIL reset_fill_entry: got level=%0d echo=%b ovf=%b want 0 0 0", level, echo_en, ovf);
        end
    endtask

    task automatic test_fill_run;
        bit w, r, ea, eaf; int np; logic [AW:0] el;
        for (int i = 1; i <= 6; i++) begin
            pulse_once(4, 4, w, r, ea, eaf, np);
            el = (i <= 4) ? AW'(i) : 7'd4;
            n_vec++;
            if (np != 1 || w !== 1'b1 || r !== (i >= 5) || level !== el) begin
                n_err++;
                $display("FAIL fill_pulse%0d: got n=%0d wr=%b rd=%b level=%0d want n=1 wr=1 rd=%b level=%0d",
                         i, np, w, r, level, (i >= 5), el);
            end
            if (i == 5) begin
                n_vec++;
                if (ea !== 1'b0 || eaf !== 1'b1) begin
                    n_err++; $display("FAIL fill_echo_en: got at=%b after=%b want 0 1", ea, eaf);
                end
            end
        end
    endtask

    task automatic test_delay_change;
        bit w, r, ea, eaf; int np, base;
        base = rd_total;
        delay_sel = 4'd1;
        pulse_once(4, 4, w, r, ea, eaf, np);
        n_vec++;
        if (w !== 1'b0 || r !== 1'b0 || eaf !== 1'b0) begin
            n_err++; $display("FAIL change_pulse: got wr=%b rd=%b echo=%b want 0 0 0", w, r, eaf);
        end
        idle(10);
        n_vec++;
        if (rd_total - base != 4) begin n_err++; $display("FAIL change_drain: got %0d reads want 4", rd_total - base); end
        for (int i = 1; i <= 9; i++) begin
            pulse_once(4, 4, w, r, ea, eaf, np);
            n_vec++;
            if (w !== 1'b1 || r !== (i == 9) || (i == 9 && eaf !== 1'b1)) begin
                n_err++; $display("FAIL change_refill%0d: got wr=%b rd=%b echo=%b want 1 %b %b", i, w, r, eaf, (i == 9), (i == 9));
            end
        end
    endtask

    task automatic test_clamp;
        bit w, r, ea, eaf; int np, base, bad;
        base = rd_total;
        delay_sel = 4'd15;
        pulse_once(4, 4, w, r, ea, eaf, np);
        idle(12);
        n_vec++;
        if (rd_total - base != 8) begin n_err++; $display("FAIL clamp_drain: got %0d reads want 8", rd_total - base); end
        bad = 0;
        for (int i = 1; i <= 63; i++) begin
            pulse_once(4, 4, w, r, ea, eaf, np);
            if (w !== 1'b1 || r !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0 || level !== 7'd63) begin
            n_err++; $display("FAIL clamp_fill: got %0d bad pulses level=%0d want 0 and 63", bad, level);
        end
        pulse_once(4, 4, w, r, ea, eaf, np);
        n_vec++;
        if (w !== 1'b1 || r !== 1'b1 || eaf !== 1'b1 || level !== 7'd63) begin
            n_err++; $display("FAIL clamp_run: got wr=%b rd=%b echo=%b level=%0d want 1 1 1 63", w, r, eaf, level);
        end
    endtask

    task automatic test_overflow;
        bit w, r, ea, eaf; int np;
        force_full = 1'b1;
        pulse_once(4, 4, w, r, ea, eaf, np);
        force_full = 1'b0;
        n_vec++;
        if (w !== 1'b0 || ovf !== 1'b1 || eaf !== 1'b0) begin
            n_err++; $display("FAIL ovf_full: got wr=%b ovf=%b echo=%b want 0 1 0", w, ovf, eaf);
        end
        idle(80);
        pulse_once(4, 4, w, r, ea, eaf, np);
        pulse_once(4, 4, w, r, ea, eaf, np);
        n_vec++;
        if (ovf !== 1'b1 || level !== 7'd2) begin
            n_err++; $display("FAIL ovf_sticky: got ovf=%b level=%0d want 1 2", ovf, level);
        end
    endtask

    task automatic test_strobe_sync;
        bit w, r, ea, eaf; int np, total, bad;
        total = 0; bad = 0;
        for (int i = 0; i < 100; i++) begin
            pulse_once($urandom_range(3, 6), $urandom_range(3, 6), w, r, ea, eaf, np);
            total += np;
            if (np != 1) bad++;
        end
        n_vec++;
        if (total != 100 || bad != 0) begin
            n_err++; $display("FAIL strobe_count: got %0d pulses %0d bad strobes want 100 and 0", total, bad);
        end
    endtask

    task automatic test_random;
        int hold;
        logic [AW+5:0] obs_v, exp_v;
        logic [AW:0] el;
        hold = 0;
        fifo_preset = $urandom_range(0, 6);
        for (int c = 0; c < 2000; c++) begin
            if (c == 900) reset = 1'b1;
            if (c == 903) reset = 1'b0;
            if (hold == 0) begin data_valid = ~data_valid; hold = $urandom_range(3, 7); end
            else hold--;
            if ($urandom_range(0, 79) == 0) delay_sel = 4'($urandom_range(0, 2));
            force_full = ($urandom_range(0, 299) == 0);
            @(negedge sysclk); #1;
            el = m_lvl[AW:0];
            exp_v = {m_pulse, e_wr, e_rd, m_echo, m_ovf, el};
            obs_v = {sample_pulse, fifo_wrreq, fifo_rdreq, echo_en, ovf, level};
            n_vec++;
            if (obs_v !== exp_v) begin
                n_err++; $display("FAIL random cyc%0d pulse/wr/rd/echo/ovf/level: got %b want %b", c, obs_v, exp_v);
            end
            @(posedge sysclk); #1;
        end
        force_full = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic test_protocol;
        n_vec++;
        if (viol != 0) begin n_err++; $display("FAIL flag_protocol: got %0d req-vs-flag violations want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_fill_run();
        test_delay_change();
        test_clamp();
        test_overflow();
        test_strobe_sync();
        test_random();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
